// File: rtl/trace_drain.sv
// Trace FIFO drain: pops one 7-word hart trace record, buffers it locally and
// streams it as 7 beats on a 32-bit valid/ready port, tracking drained records and index gaps.
module trace_drain #(
  parameter int unsigned LOST_W = 16,
  parameter int unsigned REC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_stats,
  input  logic              fifo_rd_empty,
  output logic              fifo_rd_en,
  input  logic [31:0]       fifo_index,
  input  logic [31:0]       fifo_pc,
  input  logic [31:0]       fifo_code,
  input  logic [31:0]       fifo_ra,
  input  logic [31:0]       fifo_sp,
  input  logic [31:0]       fifo_a0,
  input  logic [31:0]       fifo_t0,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic [2:0]        m_word,
  output logic              busy,
  output logic [REC_W-1:0]  rec_cnt,
  output logic [LOST_W-1:0] lost_cnt,
  output logic              lost_flag
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NWORDS  = 7;
  localparam int unsigned WORD_W  = 3;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NWORDS - 1);
  localparam logic [LOST_W-1:0] LOST_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   rec_q [NWORDS];
  logic [DATA_W-1:0]   fifo_vec [NWORDS];
  logic [DATA_W-1:0]   prev_index_q;
  logic                have_prev_q;

  logic                fifo_rd_en_d, busy_d, m_valid_d, m_last_d;
  logic [DATA_W-1:0]   m_data_d;
  logic [WORD_W-1:0]   m_word_d;

  logic                beat_hs, rec_done, gap;
  logic [DATA_W-1:0]   next_index, missing;
  logic [DATA_W:0]     lost_sum;
  logic [LOST_W-1:0]   lost_sat;

  // FIFO outputs in stream order
  always_comb begin
    fifo_vec[0] = fifo_index;
    fifo_vec[1] = fifo_pc;
    fifo_vec[2] = fifo_code;
    fifo_vec[3] = fifo_ra;
    fifo_vec[4] = fifo_sp;
    fifo_vec[5] = fifo_a0;
    fifo_vec[6] = fifo_t0;
  end

  assign beat_hs  = (state_q == SEND) && m_ready;
  assign rec_done = beat_hs && (word_q == LAST_WORD);

  // Index gap detection; missing count accumulates modulo 2^32 then saturates
  always_comb begin
    next_index = prev_index_q + 32'd1;
    missing    = fifo_index - prev_index_q - 32'd1;
    gap        = (state_q == LATCH) && have_prev_q && (fifo_index != next_index);
    lost_sum   = (DATA_W + 1)'(lost_cnt) + (DATA_W + 1)'(missing);
    lost_sat   = (lost_sum > (DATA_W + 1)'(LOST_MAX)) ? LOST_MAX : lost_sum[LOST_W-1:0];
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    case (state_q)
      IDLE:  if (enable && !fifo_rd_empty) state_d = POP;
      POP:   state_d = LATCH;
      LATCH: begin
        state_d = SEND;
        word_d  = '0;
      end
      SEND: begin
        if (beat_hs) begin
          if (word_q == LAST_WORD) begin
            state_d = IDLE;
            word_d  = '0;
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    fifo_rd_en_d = (state_d == POP);
    busy_d       = (state_d != IDLE);
    m_valid_d    = (state_d == SEND);
    m_last_d     = (state_d == SEND) && (word_d == LAST_WORD);
    m_word_d     = (state_d == SEND) ? word_d : '0;
    m_data_d     = '0;
    if (state_q == LATCH) begin
      m_data_d = fifo_index;
    end else if (state_d == SEND) begin
      m_data_d = rec_q[word_d];
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_word     <= '0;
      m_data     <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      fifo_rd_en <= fifo_rd_en_d;
      busy       <= busy_d;
      m_valid    <= m_valid_d;
      m_last     <= m_last_d;
      m_word     <= m_word_d;
      m_data     <= m_data_d;
    end
  end

  // Record buffer and last-seen index; buffer isolates the record from FIFO overwrites
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NWORDS); i++) rec_q[i] <= '0;
      prev_index_q <= '0;
      have_prev_q  <= 1'b0;
    end else if (state_q == LATCH) begin
      for (int i = 0; i < int'(NWORDS); i++) rec_q[i] <= fifo_vec[i];
      prev_index_q <= fifo_index;
      have_prev_q  <= 1'b1;
    end
  end

  // Statistics; a clear wins over any same-cycle update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_cnt   <= '0;
      lost_cnt  <= '0;
      lost_flag <= 1'b0;
    end else if (clr_stats) begin
      rec_cnt   <= '0;
      lost_cnt  <= '0;
      lost_flag <= 1'b0;
    end else begin
      if (rec_done) rec_cnt <= rec_cnt + REC_W'(1);
      if (gap) begin
        lost_cnt  <= lost_sat;
        lost_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_drain.sv
// Directed bench for trace_drain: a one-record FIFO model feeds two instances
// (default LOST_W and LOST_W=4) and every beat and statistic is checked.
module tb_trace_drain;

  logic        clk = 1'b0;
  logic        rst, enable, clr_stats, fifo_rd_empty, m_ready;
  logic [31:0] fifo_index, fifo_pc, fifo_code, fifo_ra, fifo_sp, fifo_a0, fifo_t0;

  logic        fifo_rd_en, m_valid, m_last, busy, lost_flag;
  logic [31:0] m_data, rec_cnt;
  logic [2:0]  m_word;
  logic [15:0] lost_cnt;

  logic        d4_fifo_rd_en, d4_m_valid, d4_m_last, d4_busy, d4_lost_flag;
  logic [31:0] d4_m_data, d4_rec_cnt;
  logic [2:0]  d4_m_word;
  logic [3:0]  d4_lost_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          pop_cnt = 0;
  logic [31:0] rv [7];

  always #5 clk = ~clk;

  always @(negedge clk) if (fifo_rd_en) pop_cnt++;

  trace_drain dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_stats(clr_stats),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_index(fifo_index), .fifo_pc(fifo_pc), .fifo_code(fifo_code),
    .fifo_ra(fifo_ra), .fifo_sp(fifo_sp), .fifo_a0(fifo_a0), .fifo_t0(fifo_t0),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_word(m_word), .busy(busy), .rec_cnt(rec_cnt), .lost_cnt(lost_cnt),
    .lost_flag(lost_flag)
  );

  trace_drain #(.LOST_W(4), .REC_W(32)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .clr_stats(clr_stats),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(d4_fifo_rd_en),
    .fifo_index(fifo_index), .fifo_pc(fifo_pc), .fifo_code(fifo_code),
    .fifo_ra(fifo_ra), .fifo_sp(fifo_sp), .fifo_a0(fifo_a0), .fifo_t0(fifo_t0),
    .m_valid(d4_m_valid), .m_ready(m_ready), .m_data(d4_m_data), .m_last(d4_m_last),
    .m_word(d4_m_word), .busy(d4_busy), .rec_cnt(d4_rec_cnt), .lost_cnt(d4_lost_cnt),
    .lost_flag(d4_lost_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input logic [31:0] idx);
    rv[0] = idx;
    rv[1] = 32'h8000_0000 + (idx << 2);
    rv[2] = 32'h0000_0013;
    rv[3] = 32'h8000_0010 ^ idx;
    rv[4] = 32'h8000_1000;
    rv[5] = idx + 32'd5;
    rv[6] = 32'h0000_0007;
  endtask

  task automatic put_fifo(input logic [31:0] base, input bit garbage);
    fifo_index = garbage ? base ^ 32'hDEAD_0000 : rv[0];
    fifo_pc    = garbage ? base ^ 32'hDEAD_0001 : rv[1];
    fifo_code  = garbage ? base ^ 32'hDEAD_0002 : rv[2];
    fifo_ra    = garbage ? base ^ 32'hDEAD_0003 : rv[3];
    fifo_sp    = garbage ? base ^ 32'hDEAD_0004 : rv[4];
    fifo_a0    = garbage ? base ^ 32'hDEAD_0005 : rv[5];
    fifo_t0    = garbage ? base ^ 32'hDEAD_0006 : rv[6];
  endtask

  // Drain one record held in rv; optional stall, clear-at-LATCH and reset-at-beat
  task automatic run_record(input int stall_w, input int stall_n, input bit clr_latch, input int rst_w);
    int  p0;
    bit  seen;
    p0   = pop_cnt;
    seen = 1'b0;
    fifo_rd_empty = 1'b0;
    enable        = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (fifo_rd_en === 1'b1) seen = 1'b1;
    end
    chk("pop_seen", 32'(seen), 32'd1);
    if (!seen) return;
    tick();
    put_fifo(32'h0, 1'b0);
    fifo_rd_empty = 1'b1;
    enable        = 1'b0;
    clr_stats     = clr_latch;
    chk("pop_one_cycle", 32'(fifo_rd_en), 32'd0);
    chk("latch_busy", 32'(busy), 32'd1);
    tick();
    clr_stats = 1'b0;
    put_fifo(rv[0], 1'b1);
    for (int w = 0; w < 7; w++) begin
      chk($sformatf("beat%0d_valid", w), 32'(m_valid), 32'd1);
      chk($sformatf("beat%0d_data", w), m_data, rv[w]);
      chk($sformatf("beat%0d_word", w), 32'(m_word), 32'(w));
      chk($sformatf("beat%0d_last", w), 32'(m_last), 32'(w == 6));
      if (w == rst_w) begin
        rst = 1'b1;
        #1;
        chk("rst_valid_drop", 32'(m_valid), 32'd0);
        chk("rst_busy_drop", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        return;
      end
      if (w == stall_w) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", m_data, rv[w]);
          chk("stall_word", 32'(m_word), 32'(w));
        end
        m_ready = 1'b1;
      end
      tick();
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(m_valid), 32'd0);
    chk("pop_count", 32'(pop_cnt - p0), 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr_stats = 1'b0; fifo_rd_empty = 1'b1; m_ready = 1'b1;
    set_rec(32'd0);
    put_fifo(32'h0, 1'b1);
    repeat (3) tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_word_last", {28'd0, m_word, m_last}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stats", rec_cnt | 32'(lost_cnt) | 32'(lost_flag), 32'd0);
    rst = 1'b0;

    // Empty FIFO with drain enabled: never pops
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_no_pop", 32'(fifo_rd_en), 32'd0);
    end
    chk("empty_busy", 32'(busy), 32'd0);

    // Reference record
    rv[0] = 32'h0; rv[1] = 32'h8000_0000; rv[2] = 32'h0000_0013; rv[3] = 32'h8000_0010;
    rv[4] = 32'h8000_1000; rv[5] = 32'h5; rv[6] = 32'h7;
    run_record(-1, 0, 1'b0, -1);
    chk("rec1_cnt", rec_cnt, 32'd1);

    // Backpressure at word 2
    set_rec(32'd1);
    run_record(2, 3, 1'b0, -1);
    chk("bp_rec_cnt", rec_cnt, 32'd2);
    chk("bp_lost", 32'(lost_cnt), 32'd0);

    // Index wrap is not a gap
    pulse_rst();
    set_rec(32'hFFFF_FFFF); run_record(-1, 0, 1'b0, -1);
    set_rec(32'h0);         run_record(-1, 0, 1'b0, -1);
    chk("wrap_lost", 32'(lost_cnt), 32'd0);
    chk("wrap_flag", 32'(lost_flag), 32'd0);
    chk("wrap_rec_cnt", rec_cnt, 32'd2);

    // Gap 5 -> 9, then contiguous 10
    pulse_rst();
    set_rec(32'd5);  run_record(-1, 0, 1'b0, -1);
    set_rec(32'd9);  run_record(-1, 0, 1'b0, -1);
    chk("gap_lost", 32'(lost_cnt), 32'd3);
    chk("gap_flag", 32'(lost_flag), 32'd1);
    chk("gap_lost4", 32'(d4_lost_cnt), 32'd3);
    set_rec(32'd10); run_record(-1, 0, 1'b0, -1);
    chk("contig_lost", 32'(lost_cnt), 32'd3);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_lost", 32'(lost_cnt), 32'd0);
    chk("clr_flag", 32'(lost_flag), 32'd0);
    chk("clr_rec_cnt", rec_cnt, 32'd0);

    // Saturation on the 4-bit instance
    pulse_rst();
    set_rec(32'd0);  run_record(-1, 0, 1'b0, -1);
    set_rec(32'd20); run_record(-1, 0, 1'b0, -1);
    chk("sat_lost16", 32'(lost_cnt), 32'd19);
    chk("sat_lost4", 32'(d4_lost_cnt), 32'd15);
    chk("sat_flag4", 32'(d4_lost_flag), 32'd1);

    // Clear coincident with a gap at LATCH drops the gap
    set_rec(32'd22); run_record(-1, 0, 1'b1, -1);
    chk("clrgap_lost", 32'(lost_cnt), 32'd0);
    chk("clrgap_lost4", 32'(d4_lost_cnt), 32'd0);
    chk("clrgap_flag", 32'(lost_flag), 32'd0);
    chk("clrgap_rec_cnt", rec_cnt, 32'd1);

    // Reset at word 3 of a gapped record, then a fresh record
    set_rec(32'd50);  run_record(-1, 0, 1'b0, 3);
    chk("abort_rec_cnt", rec_cnt, 32'd0);
    chk("abort_lost", 32'(lost_cnt), 32'd0);
    tick();
    set_rec(32'd100); run_record(-1, 0, 1'b0, -1);
    chk("post_rst_lost", 32'(lost_cnt), 32'd0);
    chk("post_rst_flag", 32'(lost_flag), 32'd0);
    chk("post_rst_rec_cnt", rec_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
